// File: rtl/seg_led_scanner_pkg.sv
// Shared constants for the seven-segment scanner: glyph table, segment bit positions,
// and the helper that applies output polarity.
package seg_led_scanner_pkg;

    localparam int unsigned SEG_A_BIT  = 0;
    localparam int unsigned SEG_B_BIT  = 1;
    localparam int unsigned SEG_C_BIT  = 2;
    localparam int unsigned SEG_D_BIT  = 3;
    localparam int unsigned SEG_E_BIT  = 4;
    localparam int unsigned SEG_F_BIT  = 5;
    localparam int unsigned SEG_G_BIT  = 6;
    localparam int unsigned SEG_DP_BIT = 7;

    // Glyphs are {g,f,e,d,c,b,a}, 1 = segment lit
    localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
    localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
    localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
    localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
    localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
    localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
    localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
    localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
    localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
    localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
    localparam logic [6:0] SEG_GLYPH_A = 7'h77;
    localparam logic [6:0] SEG_GLYPH_B = 7'h7C;
    localparam logic [6:0] SEG_GLYPH_C = 7'h39;
    localparam logic [6:0] SEG_GLYPH_D = 7'h5E;
    localparam logic [6:0] SEG_GLYPH_E = 7'h79;
    localparam logic [6:0] SEG_GLYPH_F = 7'h71;

    localparam logic [7:0] SEG_OFF = 8'h00;

    function automatic logic [7:0] seg_apply_polarity(input logic [7:0] seg_lit, input logic act);
        return act ? seg_lit : ~seg_lit;
    endfunction

endpackage

// File: rtl/seg_led_scanner_if.sv
// CPU-side write port of the scanner: data/mask write strobe plus commit status back.
interface seg_led_scanner_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  wr_stb;
    logic [4*DIGITS-1:0]   wr_hex;
    logic [DIGITS-1:0]     wr_dp;
    logic [DIGITS-1:0]     wr_blank;
    logic                  busy;
    logic                  upd_done;

    modport master (
        output wr_stb, wr_hex, wr_dp, wr_blank,
        input  busy, upd_done
    );

    modport slave (
        input  wr_stb, wr_hex, wr_dp, wr_blank,
        output busy, upd_done
    );
endinterface

// File: rtl/seg_led_scanner_seg7_decode.sv
// Combinational hex nibble to seven-segment glyph decoder (active-high segments).
module seg_led_scanner_seg7_decode
    import seg_led_scanner_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] glyph
);
    always_comb begin
        glyph = SEG_GLYPH_0;
        case (hex)
            4'h0: glyph = SEG_GLYPH_0;
            4'h1: glyph = SEG_GLYPH_1;
            4'h2: glyph = SEG_GLYPH_2;
            4'h3: glyph = SEG_GLYPH_3;
            4'h4: glyph = SEG_GLYPH_4;
            4'h5: glyph = SEG_GLYPH_5;
            4'h6: glyph = SEG_GLYPH_6;
            4'h7: glyph = SEG_GLYPH_7;
            4'h8: glyph = SEG_GLYPH_8;
            4'h9: glyph = SEG_GLYPH_9;
            4'hA: glyph = SEG_GLYPH_A;
            4'hB: glyph = SEG_GLYPH_B;
            4'hC: glyph = SEG_GLYPH_C;
            4'hD: glyph = SEG_GLYPH_D;
            4'hE: glyph = SEG_GLYPH_E;
            default: glyph = SEG_GLYPH_F;
        endcase
    end
endmodule

// File: rtl/seg_led_scanner.sv
// Multiplexed N-digit seven-segment scanner with frame-aligned double buffering and dead-time.
// Optional brightness control is enabled by defining SEG_LED_DIMMING_EN.
module seg_led_scanner
    import seg_led_scanner_pkg::*;
#(
    parameter int unsigned DIGITS        = 2,
    parameter int unsigned OSC_CLOCK     = 24000000,
    parameter int unsigned REFRESH_CLOCK = 50,
    parameter int unsigned DEADTIME      = 4,
    parameter logic        ANODE_ACT     = 1'b0,
    parameter logic        SEG_ACT       = 1'b0
) (
    input  logic              sys_clk,
    input  logic              sys_res,
    seg_led_scanner_if.slave  bus,
`ifdef SEG_LED_DIMMING_EN
    input  logic [3:0]        bright,
`endif
    output logic              frame_tick,
    output logic [DIGITS-1:0] anode,
    output logic [7:0]        seg
);
    localparam int unsigned SLOT_LEN = OSC_CLOCK / (REFRESH_CLOCK * DIGITS);
    localparam int unsigned PW       = $clog2(SLOT_LEN);
    localparam int unsigned IW       = $clog2(DIGITS);

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_hex_q, disp_hex_q;
    logic [DIGITS-1:0]   shadow_dp_q, disp_dp_q;
    logic [DIGITS-1:0]   shadow_blank_q, disp_blank_q;
    logic                busy_q, upd_done_q;
    logic [DIGITS-1:0]   anode_q, anode_d;
    logic [7:0]          seg_q, seg_d;

    logic                slot_end, frame_end, commit;
    logic [3:0]          hex_sel;
    logic                dp_sel, blank_sel;
    logic [6:0]          glyph;
    logic                dim_ok, seg_on;

    assign slot_end  = (presc_q == PW'(SLOT_LEN - 1));
    assign frame_end = slot_end && (idx_q == IW'(DIGITS - 1));
    assign commit    = frame_end && busy_q;

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (slot_end) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    always_comb begin
        hex_sel   = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                hex_sel   = disp_hex_q[4*i +: 4];
                dp_sel    = disp_dp_q[i];
                blank_sel = disp_blank_q[i];
            end
        end
    end

    seg_led_scanner_seg7_decode u_decode (
        .hex   (hex_sel),
        .glyph (glyph)
    );

`ifdef SEG_LED_DIMMING_EN
    localparam int unsigned ON_SPAN = SLOT_LEN - DEADTIME;
    logic [3:0]  bright_q;
    logic [31:0] dim_limit;

    // Unsigned wrap makes the dead-time region fail this test as well
    assign dim_limit = (ON_SPAN * (32'(bright_q) + 32'd1)) >> 4;
    assign dim_ok    = ((32'(presc_q) - DEADTIME) < dim_limit);
`else
    assign dim_ok = 1'b1;
`endif

    assign seg_on = (32'(presc_q) >= DEADTIME) && !blank_sel && dim_ok;

    always_comb begin
        seg_d = seg_apply_polarity(seg_on ? {dp_sel, glyph} : SEG_OFF, SEG_ACT);
        for (int i = 0; i < int'(DIGITS); i++) begin
            anode_d[i] = (idx_q == IW'(i)) ? ANODE_ACT : ~ANODE_ACT;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_res) begin
            presc_q        <= '0;
            idx_q          <= '0;
            shadow_hex_q   <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            disp_hex_q     <= '0;
            disp_dp_q      <= '0;
            disp_blank_q   <= '0;
            busy_q         <= 1'b0;
            upd_done_q     <= 1'b0;
            anode_q        <= {DIGITS{~ANODE_ACT}};
            seg_q          <= {8{~SEG_ACT}};
`ifdef SEG_LED_DIMMING_EN
            bright_q       <= 4'hF;
`endif
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            // Commit reads the old shadow even when a write lands on the same cycle
            if (commit) begin
                disp_hex_q   <= shadow_hex_q;
                disp_dp_q    <= shadow_dp_q;
                disp_blank_q <= shadow_blank_q;
            end
            if (bus.wr_stb) begin
                shadow_hex_q   <= bus.wr_hex;
                shadow_dp_q    <= bus.wr_dp;
                shadow_blank_q <= bus.wr_blank;
            end
            busy_q     <= bus.wr_stb | (busy_q & ~commit);
            upd_done_q <= commit;
            anode_q    <= anode_d;
            seg_q      <= seg_d;
`ifdef SEG_LED_DIMMING_EN
            if (frame_end) begin
                bright_q <= bright;
            end
`endif
        end
    end

    assign frame_tick   = frame_end;
    assign anode        = anode_q;
    assign seg          = seg_q;
    assign bus.busy     = busy_q;
    assign bus.upd_done = upd_done_q;

endmodule

// File: tb/tb_seg_led_scanner.sv
// Randomised self-checking bench for seg_led_scanner against a cycle-count reference model.
module tb_seg_led_scanner;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned SLOT   = 5;
    localparam int unsigned FRAME  = SLOT * DIGITS;
    localparam int unsigned DT     = 1;

    logic       sys_clk = 1'b0;
    logic       sys_res;
    logic       frame_tick;
    logic [3:0] anode;
    logic [7:0] seg;
`ifdef SEG_LED_DIMMING_EN
    // Full brightness: 4*16/16 = 4 lit cycles, identical to the undimmed slot here
    logic [3:0] bright = 4'hF;
`endif

    seg_led_scanner_if #(.DIGITS(DIGITS)) bus ();

    seg_led_scanner #(
        .DIGITS        (DIGITS),
        .OSC_CLOCK     (1000),
        .REFRESH_CLOCK (50),
        .DEADTIME      (DT),
        .ANODE_ACT     (1'b0),
        .SEG_ACT       (1'b0)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_res    (sys_res),
        .bus        (bus),
`ifdef SEG_LED_DIMMING_EN
        .bright     (bright),
`endif
        .frame_tick (frame_tick),
        .anode      (anode),
        .seg        (seg)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: cycles since reset release plus shadow/display contents
    int          cyc;
    logic [15:0] m_sh_hex, m_dp_hex;
    logic [3:0]  m_sh_dp, m_dp_dp, m_sh_bl, m_dp_bl;
    bit          m_busy, m_upd;
    logic [3:0]  e_anode;
    logic [7:0]  e_seg;
    int          upd_seen;

    function automatic logic [3:0] anode_of(input int c);
        logic [3:0] a;
        a = 4'b1111;
        a[(c / SLOT) % DIGITS] = 1'b0;
        return a;
    endfunction

    function automatic logic [7:0] seg_of(input int c);
        int p;
        int i;
        p = c % SLOT;
        i = (c / SLOT) % DIGITS;
        if (p < int'(DT) || m_dp_bl[i]) return 8'hFF;
        return ~{m_dp_dp[i], glyph_tab[m_dp_hex[i*4 +: 4]]};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        if (sys_res) begin
            cyc = 0;
            m_sh_hex = '0; m_dp_hex = '0;
            m_sh_dp = '0;  m_dp_dp = '0;
            m_sh_bl = '0;  m_dp_bl = '0;
            m_busy = 0;    m_upd = 0;
            e_anode = 4'hF;
            e_seg = 8'hFF;
        end else begin
            e_anode = anode_of(cyc);
            e_seg   = seg_of(cyc);
            m_upd   = 0;
            if ((cyc % FRAME) == FRAME - 1 && m_busy) begin
                m_dp_hex = m_sh_hex;
                m_dp_dp  = m_sh_dp;
                m_dp_bl  = m_sh_bl;
                m_busy   = 0;
                m_upd    = 1;
            end
            if (bus.wr_stb) begin
                m_sh_hex = bus.wr_hex;
                m_sh_dp  = bus.wr_dp;
                m_sh_bl  = bus.wr_blank;
                m_busy   = 1;
            end
            cyc++;
        end
        #1;
        if (bus.upd_done) upd_seen++;
        check_eq("anode", anode, e_anode);
        check_eq("seg", seg, e_seg);
        check_eq("busy", bus.busy, m_busy);
        check_eq("upd_done", bus.upd_done, m_upd);
        check_eq("frame_tick", frame_tick, (cyc % FRAME) == FRAME - 1);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic write(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
        bus.wr_stb   = 1'b1;
        bus.wr_hex   = h;
        bus.wr_dp    = d;
        bus.wr_blank = b;
        tick();
        bus.wr_stb = 1'b0;
    endtask

    task automatic align(input int modulus, input int phase);
        while ((cyc % modulus) != phase) tick();
    endtask

    initial begin
        sys_res      = 1'b1;
        bus.wr_stb   = 1'b0;
        bus.wr_hex   = '0;
        bus.wr_dp    = '0;
        bus.wr_blank = '0;
        upd_seen     = 0;
        cyc          = 0;
        idle(3);
        sys_res = 1'b0;
        idle(25);

        write(16'h1234, 4'b0001, 4'b0000);
        idle(45);

        // Two writes in one frame: one commit, last value wins
        align(FRAME, 0);
        upd_seen = 0;
        write(16'hAAAA, 4'b0000, 4'b0000);
        idle(2);
        write(16'h5555, 4'b0000, 4'b0000);
        idle(2 * FRAME);
        check_eq("one_upd", upd_seen, 1);

        // Write on the frame_tick cycle: old shadow commits, new one stays pending
        write(16'h9876, 4'b1000, 4'b0000);
        align(FRAME, FRAME - 1);
        write(16'hBCDE, 4'b0110, 4'b0000);
        check_eq("busy_held", bus.busy, 1);
        idle(2 * FRAME);

        write(16'hF0F0, 4'b0000, 4'b0100);
        idle(2 * FRAME);

        // Reset mid-slot discards a pending write
        write(16'h7777, 4'b1111, 4'b0000);
        align(SLOT, 2);
        sys_res = 1'b1;
        tick();
        check_eq("busy_rst", bus.busy, 0);
        sys_res = 1'b0;
        idle(FRAME);

        for (int k = 0; k < 400; k++) begin
            bus.wr_stb   = ($urandom_range(7) == 0);
            bus.wr_hex   = 16'($urandom);
            bus.wr_dp    = 4'($urandom);
            bus.wr_blank = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
            tick();
        end
        bus.wr_stb = 1'b0;
        idle(2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
